regfile_mp: RTL and testbench

Parametrised multi-port register file: the successor to the single-write, dual-read register file in the datapath. It provides `NUM_RD` registered read ports and `NUM_WR` write ports with fixed port priority, plus a hard-wired zero register. Same-cycle write-to-read bypass is included, as is an asynchronous active-low clear. A valid/ready dump streamer reads out every register sequentially for the testbench and debug logic. It sits between decode (read addresses) and writeback (write ports), feeding ALU operands.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_dump_fsm.sv | 89 ++++++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the multi-port register file:
//   - default register count / widths / port counts
//   - ZERO_REG: the hard-wired zero register index
//   - dump_state_t: state encoding of the dump streamer
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_NUM_WR   = 2;

   // Index of the register that always reads as zero and ignores writes.
   localparam int ZERO_REG = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Valid/ready streamer that walks every register index once per dump request.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       one-cycle dump request, honoured only in IDLE
//   ready_i       consumer accepts the current beat
//   word_i        contents of register idx_o, supplied by the array
//   valid_o       beat valid (high throughout STREAM)
//   idx_o         register index of the current beat
//   data_o        beat data (combinational pass-through of word_i)
//   done_o        one-cycle pulse after the last beat has transferred
// -----------------------------------------------------------------------------
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] word_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] idx_o,
   output logic [DATA_W-1:0] data_o,
   output logic              done_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   logic              done_q,  done_d;

   // NOTE: every variable driven here gets a default before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = STREAM;
               idx_d   = '0;
            end
         end
         STREAM: begin
            // start_i is deliberately not looked at here.
            if (ready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign valid_o = (state_q == STREAM);
   assign idx_o   = idx_q;
   assign data_o  = word_i;
   assign done_o  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with registered reads, prioritised writes,
// write-to-read bypass, a hard-wired zero register and a dump streamer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low clear of all state
//   rs           NUM_RD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      NUM_RD registered read words, packed like rs
//   we           NUM_WR write enables
//   waddr        NUM_WR write addresses
//   wdata        NUM_WR write words
//   dump_start   begin a dump (ignored while one is running)
//   dump_valid   dump beat valid
//   dump_ready   consumer accepts the dump beat
//   dump_idx     register index of the current beat
//   dump_data    current contents of register dump_idx
//   dump_done    one-cycle pulse after the final beat
// When several write ports hit the same register, the highest index wins.
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rs,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic                     dump_start,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic [ADDR_W-1:0]        dump_idx,
   output logic [DATA_W-1:0]        dump_data,
   output logic                     dump_done
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0]        rd_addr [NUM_RD];
   logic [DATA_W-1:0]        rd_word [NUM_RD];
   logic [ADDR_W-1:0]        dump_idx_w;
   logic [DATA_W-1:0]        dump_word;

   // Write path. Writes to the zero register are dropped, so regs_q[0] stays
   // at its reset value of zero forever.
   always_comb begin
      regs_d = regs_q;
      // NOTE: blocking assignments in a loop evaluate in order, so a later
      // (higher-index) port overwrites an earlier one on an address clash.
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j] && (waddr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
            regs_d[waddr[j*ADDR_W +: ADDR_W]] = wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   // Read path with bypass: a same-cycle write to the read address forwards
   // its data, using the same port priority as the array update.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_addr[i] = rs[i*ADDR_W +: ADDR_W];
         rd_word[i] = regs_q[rd_addr[i]];
         for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == rd_addr[i])) begin
               rd_word[i] = wdata[j*DATA_W +: DATA_W];
            end
         end
         if (rd_addr[i] == ZERO_ADDR) begin
            rd_word[i] = '0;
         end
         rd_data_d[i*DATA_W +: DATA_W] = rd_word[i];
      end
   end

   // NOTE: the register array is cleared by the asynchronous reset because
   // the architecture requires every register to read zero after a clear;
   // this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         regs_q    <= regs_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

   // Dump read port: purely combinational from committed state.
   assign dump_word = (dump_idx_w == ZERO_ADDR) ? '0 : regs_q[dump_idx_w];

   regfile_dump_fsm #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) u_dump_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (dump_start),
      .ready_i (dump_ready),
      .word_i  (dump_word),
      .valid_o (dump_valid),
      .idx_o   (dump_idx_w),
      .data_o  (dump_data),
      .done_o  (dump_done)
   );

   assign dump_idx = dump_idx_w;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp with default parameters (32 x 32-bit,
// two read and two write ports). Inputs change 1 ns after the rising edge;
// outputs are sampled 1 ns after the edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic              clk;
   logic              rst_n;
   logic [NRD*AW-1:0] rs;
   logic [NRD*DW-1:0] rd_data;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] waddr;
   logic [NWR*DW-1:0] wdata;
   logic              dump_start;
   logic              dump_valid;
   logic              dump_ready;
   logic [AW-1:0]     dump_idx;
   logic [DW-1:0]     dump_data;
   logic              dump_done;

   regfile_mp #(
      .NUM_REGS (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .NUM_RD   (NRD),
      .NUM_WR   (NWR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs         (rs),
      .rd_data    (rd_data),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .dump_start (dump_start),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
      we    = w;
      waddr = {a1, a0};
      wdata = {d1, d0};
      rs    = {r1, r0};
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [4:0]  r0, r1;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t vecs[8];

   // Behavioural model: memory after applying writes in port order; a read
   // sees the post-write contents (write-first), register 0 always zero.
   logic [31:0] mem [NR];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          xfers;
      int          dones;
      bit          finished;
      bit          saw_done;
      bit          found;
      logic [1:0]  rw;
      logic [4:0]  ra[2];
      logic [31:0] rdat[2];
      logic [4:0]  rr[2];
      logic [31:0] exp0, exp1;

      rst_n      = 1'b0;
      dump_start = 1'b0;
      dump_ready = 1'b0;
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

      // ---------------- reset state ----------------
      #12;
      check("reset_rd_data_lo", rd_data[31:0], 32'h0);
      check("reset_rd_data_hi", rd_data[63:32], 32'h0);
      check("reset_dump_valid", {31'b0, dump_valid}, 32'h0);
      check("reset_dump_idx",   {27'b0, dump_idx}, 32'h0);
      check("reset_dump_done",  {31'b0, dump_done}, 32'h0);
      rst_n = 1'b1;
      tick();

      // ---------------- table-driven vectors ----------------
      vecs[0] = '{2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0, 5'd1, 5'd2, 32'h0, 32'h0};
      vecs[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{2'b11, 5'd3, 5'd3, 32'hAAAA0000, 32'h5555FFFF, 5'd3, 5'd3, 32'h5555FFFF, 32'h5555FFFF};
      vecs[3] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7, 32'h5555FFFF, 32'hDEADBEEF};
      vecs[4] = '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};
      vecs[5] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
      vecs[6] = '{2'b11, 5'd9, 5'd10, 32'h1, 32'h2, 5'd10, 5'd9, 32'h2, 32'h1};
      vecs[7] = '{2'b10, 5'd9, 5'd9, 32'h4, 32'h3, 5'd9, 5'd10, 32'h3, 32'h2};

      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].we, vecs[v].a0, vecs[v].a1, vecs[v].d0, vecs[v].d1,
               vecs[v].r0, vecs[v].r1);
         tick();
         check($sformatf("vec%0d_rd0", v), rd_data[31:0],  vecs[v].e0);
         check($sformatf("vec%0d_rd1", v), rd_data[63:32], vecs[v].e1);
      end
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
      tick();
      check("r9_holds_port1", rd_data[31:0], 32'h3);

      // ---------------- reset clears registers ----------------
      drive(2'b01, 5'd5, 5'd0, 32'h1234, 32'h0, 5'd5, 5'd5);
      tick();
      check("pre_reset_r5", rd_data[31:0], 32'h1234);
      drive(2'b01, 5'd5, 5'd0, 32'hBAD0BAD0, 32'h0, 5'd5, 5'd5);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_rd0", rd_data[31:0], 32'h0);
      check("async_reset_rd1", rd_data[63:32], 32'h0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
      tick();
      check("post_reset_r5", rd_data[31:0], 32'h0);
      check("post_reset_r7", rd_data[63:32], 32'h0);

      // ---------------- dump with backpressure ----------------
      for (int k = 1; k < NR; k++) begin
         drive(2'b01, 5'(k), 5'd0, 32'(k * 'h11), 32'h0, 5'd0, 5'd0);
         tick();
      end
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      dump_ready = 1'b0;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      check("dump_start_valid", {31'b0, dump_valid}, 32'h1);
      check("dump_start_idx",   {27'b0, dump_idx}, 32'h0);

      xfers    = 0;
      dones    = 0;
      finished = 1'b0;
      for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
         dump_ready = 1'($urandom_range(0, 1));
         dump_start = (dump_valid && dump_idx < 5'd29) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (dump_done) begin
            dones++;
            check("done_after_all_beats", xfers, 32);
            finished = 1'b1;
         end
         if (dump_valid && dump_ready) begin
            check($sformatf("dump_idx_%0d", xfers), {27'b0, dump_idx}, 32'(xfers));
            check($sformatf("dump_data_%0d", xfers), dump_data, 32'(xfers * 'h11));
            xfers++;
         end
         @(posedge clk);
         #1;
      end
      dump_start = 1'b0;
      check("dump_finished_in_budget", {31'b0, finished}, 32'h1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (dump_done) dones++;
         if (dump_valid) xfers++;
      end
      check("dump_transfer_count", xfers, 32);
      check("dump_done_pulses", dones, 1);

      // ---------------- reset mid-dump ----------------
      tick();
      dump_ready = 1'b1;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         if (dump_idx == 5'd10) found = 1'b1;
         else tick();
      end
      check("mid_dump_reached_idx10", {31'b0, found}, 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_dump_reset_valid", {31'b0, dump_valid}, 32'h0);
      check("mid_dump_reset_idx",   {27'b0, dump_idx}, 32'h0);
      saw_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dump_done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dump_done || dump_valid) saw_done = 1'b1;
      end
      check("mid_dump_no_done_or_valid", {31'b0, saw_done}, 32'h0);
      tick();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      check("restart_valid", {31'b0, dump_valid}, 32'h1);
      check("restart_idx",   {27'b0, dump_idx}, 32'h0);
      tick();
      check("restart_idx_step", {27'b0, dump_idx}, 32'h1);

      // ---------------- randomized traffic vs model ----------------
      dump_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      for (int r = 0; r < NR; r++) mem[r] = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rw = 2'($urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            ra[j]   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rdat[j] = $urandom;
            rr[j]   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         end
         for (int j = 0; j < 2; j++) begin
            if (rw[j] && ra[j] != 5'd0) mem[ra[j]] = rdat[j];
         end
         exp0 = (rr[0] == 5'd0) ? 32'h0 : mem[rr[0]];
         exp1 = (rr[1] == 5'd0) ? 32'h0 : mem[rr[1]];
         drive(rw, ra[0], ra[1], rdat[0], rdat[1], rr[0], rr[1]);
         tick();
         check($sformatf("rand%0d_rd0", cyc), rd_data[31:0],  exp0);
         check($sformatf("rand%0d_rd1", cyc), rd_data[63:32], exp1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
